interrupt_controller: RTL
=========================

# interrupt_controller

Eight-source prioritised interrupt controller that drives the CPU's `irq` input and answers its `iack` handshake with a vector. It sits between peripheral interrupt lines and the control FSM. It is programmed over the same single-cycle memory bus the CPU uses for `read`/`write`. It tracks pending and in-service state so that only a strictly higher-priority source can nest.

## Interface
- No parameters; eight sources and 16-bit data are fixed.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `src` in 8: raw interrupt lines, asynchronous, rising-edge sensitive; bit 0 has the highest priority.
- `sel` in 1: bus select for this block.
- `read` in 1: bus read strobe, qualified by `sel`.
- `write` in 1: bus write strobe, qualified by `sel`.
- `addr` in 2: register select.
- `wdata` in 16: bus write data.
- `rdata` out 16: register read data, combinational from `addr`; 0 when `sel`&`read` is low.
- `irq` out 1: registered interrupt request to the CPU.
- `iack` in 1: CPU acknowledge, held high until the CPU has consumed `vector`.
- `vector` out 16: registered vector, valid while state is ACK.

## Operation
- Input path: 2-flop synchroniser per `src` bit, then rising-edge detect (s2 & ~s3). A detected edge sets `pending[n]`.
- Registers:
  - addr 0 PENDING: read returns {8'h00, pending}. Write is write-1-to-clear on bits [7:0].
  - addr 1 MASK: read/write bits [7:0]; 1 = masked. Reset value 8'hFF.
  - addr 2 VBASE: read/write, 16 bits. Reset value 16'h0000.
  - addr 3 STATUS/EOI: read returns {in_service[7:0], 4'h0, cur_id[3:0]}. Any write is an EOI: it clears the lowest-numbered set `in_service` bit. EOI with `in_service`==0 is a no-op.
- Candidate: the lowest index n with pending[n] & ~mask[n] and n < the lowest set in_service index (any n if none is in service).
- FSM states are IDLE, REQ and ACK. The state is 2 bits; the encoding is free.
  - IDLE: `irq`=0. Go to REQ when a candidate exists.
  - REQ: `irq`=1. Return to IDLE, dropping `irq`, if the candidate vanishes before `iack` (mask write, W1C, or EOI reordering).
  - REQ with `iack`=1: go to ACK and latch the current candidate id into `cur_id`. Clear its `pending` bit and set its `in_service` bit. Set `vector` = VBASE + (id<<1), modulo 2^16.
  - REQ with `iack`=1 and no candidate in the same cycle: go to ACK with `cur_id`=8 and `vector`=VBASE+16 (spurious). `pending`/`in_service` are unchanged.
  - ACK: `irq`=0; `vector` holds. Go to IDLE when `iack`=0.
  - IDLE with `iack`=1: treated as spurious, identical to the spurious REQ case.
- Simultaneous events:
  - Edge detect and clear of the same pending bit (W1C or ack capture) in one cycle: set wins.
  - EOI and ack capture in one cycle: the EOI is applied to `in_service` first, then the new bit is set.
  - Register write and ack capture in one cycle: both take effect. The candidate is evaluated on pre-write values.

## Timing
- Reset values: `irq`=0, `vector`=0, `rdata`=0, `cur_id`=0, state IDLE, pending=0, in_service=0, mask=FF, VBASE=0, synchronisers 0.
- Reset asserted mid-handshake returns to IDLE at once. `irq` and `vector` go to 0 regardless of `iack`.
- Edge latency: with `src[n]` high before edge k, pending[n] is set at edge k+2, and `irq` rises at edge k+3 (if unmasked and of sufficient priority).
- `irq` is a flop output: it rises one cycle after the candidate appears and falls one cycle after a candidate loss or `iack` capture.
- `vector` is valid from the edge that samples `iack`=1 until the edge after `iack` falls.
- A source held high produces exactly one pending set; it must go low for at least 2 cycles to retrigger.

## Test plan
- Reset, MASK=00, pulse `src[3]` for 3 cycles -> `irq` high 3 cycles later; assert `iack` -> `vector`=0x0006, PENDING=00, STATUS=0x0803; drop `iack` -> IDLE, `irq` 0.
- VBASE=0xFFF8, MASK=00, `src[5]` and `src[2]` rising together -> first `iack` gives 0xFFFC (id 2). Id 5 does not raise `irq` until an EOI is written; it then acks as 0x0002 (wraps).
- Nesting: id 4 in service, `src[1]` edge -> `irq` rises, ack gives id 1, STATUS in_service=0x12. First EOI -> 0x10, second EOI -> 0x00.
- Candidate loss: `irq` high for id 6, write MASK=0x40 before `iack` -> `irq` 0 next cycle. A later `iack` returns VBASE+16 and STATUS cur_id=8.
- W1C race: write PENDING=0x01 in the same cycle a new `src[0]` edge is detected -> pending[0] stays 1.
- Async reset low during ACK with `iack` held high -> `irq`=0, `vector`=0 immediately, MASK reads 0x00FF after release.

Source files
------------

// File: rtl/interrupt_controller.sv
// Eight-source prioritised interrupt controller.
// Synchronises and edge-detects the raw source lines, keeps pending/mask/
// in-service state, and runs a small request/acknowledge FSM towards the CPU.
// Source 0 has the highest priority. Only a source strictly above the
// highest-priority in-service source may nest.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding, irq low
// REQ   | candidate present, irq high, waiting for iack
// ACK   | iack seen, vector/cur_id latched, waiting for iack to drop
module interrupt_controller (
  input  logic        i_clk,
  input  logic        i_reset,   // asynchronous, active-low
  input  logic [7:0]  i_src,
  input  logic        i_sel,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [1:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_irq,
  input  logic        i_iack,
  output logic [15:0] o_vector
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_VBASE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam logic [3:0]  SPURIOUS_ID  = 4'd8;
  localparam logic [15:0] SPURIOUS_OFS = 16'd16;

  logic [7:0]  r_s1;
  logic [7:0]  r_s2;
  logic [7:0]  r_s3;
  logic [7:0]  r_pending;
  logic [7:0]  r_mask;
  logic [15:0] r_vbase;
  logic [7:0]  r_in_service;
  logic [1:0]  r_state;
  logic        r_irq;
  logic [15:0] r_vector;
  logic [3:0]  r_cur_id;

  logic [7:0]  w_edge;
  logic        w_wr;
  logic        w_rd;
  logic        w_eoi;
  logic [7:0]  w_is_low;
  logic [7:0]  w_allow;
  logic [7:0]  w_elig;
  logic [7:0]  w_cand_oh;
  logic        w_cand_valid;
  logic [2:0]  w_cand_id;
  logic        w_capture;
  logic [7:0]  w_ack_oh;
  logic [7:0]  w_w1c;
  logic [7:0]  w_eoi_clr;
  logic [15:0] w_cand_vector;

  assign w_wr = i_sel & i_write;
  assign w_rd = i_sel & i_read;
  assign w_eoi = w_wr && (i_addr == ADDR_STATUS);

  // A freshly synchronised high that was low one cycle earlier is an edge.
  assign w_edge = r_s2 & ~r_s3;

  // Lowest set in-service bit; everything strictly below it may nest.
  assign w_is_low = r_in_service & (~r_in_service + 8'd1);
  assign w_allow  = (r_in_service == 8'd0) ? 8'hFF : (w_is_low - 8'd1);

  assign w_elig       = r_pending & ~r_mask & w_allow;
  assign w_cand_oh    = w_elig & (~w_elig + 8'd1);
  assign w_cand_valid = |w_elig;

  // Priority encoder: lowest eligible index wins.
  always_comb begin
    w_cand_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_elig[i]) w_cand_id = i[2:0];
    end
  end

  assign w_cand_vector = r_vbase + {12'd0, w_cand_id, 1'b0};

  // Capture only happens from REQ with a live candidate; otherwise iack is spurious.
  assign w_capture = (r_state == ST_REQ) && i_iack && w_cand_valid;
  assign w_ack_oh  = w_capture ? w_cand_oh : 8'd0;

  assign w_w1c     = (w_wr && (i_addr == ADDR_PENDING)) ? i_wdata[7:0] : 8'd0;
  assign w_eoi_clr = w_eoi ? w_is_low : 8'd0;

  // Two-flop synchroniser plus one history stage for edge detection.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1 <= 8'd0;
      r_s2 <= 8'd0;
      r_s3 <= 8'd0;
    end else begin
      r_s1 <= i_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pending bits: clears (W1C, capture) lose against a same-cycle edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= 8'd0;
    end else begin
      r_pending <= (r_pending & ~(w_w1c | w_ack_oh)) | w_edge;
    end
  end

  // In-service bits: EOI is applied before the newly captured bit is set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_in_service <= 8'd0;
    end else begin
      r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_oh;
    end
  end

  // Mask and vector base configuration registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mask  <= 8'hFF;
      r_vbase <= 16'h0000;
    end else if (w_wr) begin
      if (i_addr == ADDR_MASK)  r_mask  <= i_wdata[7:0];
      if (i_addr == ADDR_VBASE) r_vbase <= i_wdata;
    end
  end

  // Request/acknowledge FSM driving irq, vector and cur_id.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_irq    <= 1'b0;
      r_vector <= 16'h0000;
      r_cur_id <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_iack) begin
            r_state  <= ST_ACK;
            r_irq    <= 1'b0;
            r_cur_id <= SPURIOUS_ID;
            r_vector <= r_vbase + SPURIOUS_OFS;
          end else if (w_cand_valid) begin
            r_state <= ST_REQ;
            r_irq   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_iack) begin
            r_state <= ST_ACK;
            r_irq   <= 1'b0;
            if (w_cand_valid) begin
              r_cur_id <= {1'b0, w_cand_id};
              r_vector <= w_cand_vector;
            end else begin
              r_cur_id <= SPURIOUS_ID;
              r_vector <= r_vbase + SPURIOUS_OFS;
            end
          end else if (!w_cand_valid) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
          end
        end
        ST_ACK: begin
          r_irq <= 1'b0;
          if (!i_iack) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read-back, zero unless a qualified read.
  always_comb begin
    o_rdata = 16'h0000;
    if (w_rd) begin
      case (i_addr)
        ADDR_PENDING: o_rdata = {8'h00, r_pending};
        ADDR_MASK:    o_rdata = {8'h00, r_mask};
        ADDR_VBASE:   o_rdata = r_vbase;
        ADDR_STATUS:  o_rdata = {r_in_service, 4'h0, r_cur_id};
        default:      o_rdata = 16'h0000;
      endcase
    end
  end

  assign o_irq    = r_irq;
  assign o_vector = r_vector;

endmodule
